// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit that owns the HI/LO architectural registers.
// A request from ID/EX moves the FSM into a 32-cycle bit-serial loop. Multiply
// uses shift-add and divide uses restoring division, both on operand
// magnitudes. A single FIX cycle then applies the result signs and writes
// HI/LO. A divide by zero skips the loop entirely.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   start           multiply/divide request held in ID/EX
//   op              00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b            operands
//   flush           exception flush; aborts or refuses the operation
//   hi_we, lo_we    MTHI / MTLO write enables (honoured only when idle)
//   wdata           MTHI / MTLO write data
//   hi, lo          HI and LO architectural registers
//   stall           combinational; freezes PC, IF/ID and ID/EX
//   done            registered one-cycle pulse when HI/LO were just updated
//   div0            registered divide-by-zero flag, valid while done=1
// -----------------------------------------------------------------------------
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        done,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  count;

  // Datapath registers, loaded when a request is accepted.
  logic        op_div;     // 1 = divide, 0 = multiply
  logic        zero_div;   // divide by zero; results preloaded, no negation
  logic        neg_lo;     // negate product (multiply) or quotient (divide)
  logic        neg_hi;     // negate remainder (signed divide only)
  logic [31:0] opnd;       // multiplicand magnitude or divisor magnitude
  logic [31:0] acc_hi;     // product high half / partial remainder
  logic [31:0] acc_lo;     // multiplier bits then product low half / quotient

  // Request decode
  logic        is_signed;
  logic        is_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        b_zero;
  logic        accept;

  // Iteration and fix-up results
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] nxt_hi;
  logic [31:0] nxt_lo;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign a_neg     = is_signed & a[31];
  assign b_neg     = is_signed & b[31];
  assign a_mag     = a_neg ? (~a + 32'd1) : a;
  assign b_mag     = b_neg ? (~b + 32'd1) : b;
  assign b_zero    = is_div & (b == 32'd0);
  assign accept    = (state == IDLE) & start & ~flush;

  assign stall = (state == CALC) | (state == FIX) | ((state == IDLE) & start & ~flush);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    mul_sum   = 33'd0;
    div_shift = 33'd0;
    div_diff  = 33'd0;
    nxt_hi    = acc_hi;
    nxt_lo    = acc_lo;

    if (op_div) begin
      // Restoring step: shift the next dividend bit into the partial
      // remainder and keep the subtraction only if it did not borrow.
      div_shift = {acc_hi, acc_lo[31]};
      div_diff  = div_shift - {1'b0, opnd};
      nxt_hi    = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
      nxt_lo    = {acc_lo[30:0], ~div_diff[32]};
    end else begin
      // Shift-add step: conditionally add the multiplicand to the high half,
      // then shift the 65-bit {carry, acc_hi, acc_lo} right by one.
      mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
      nxt_hi  = mul_sum[32:1];
      nxt_lo  = {mul_sum[0], acc_lo[31:1]};
    end
  end

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_lo ? (~prod + 64'd1) : prod;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (op_div) begin
      res_hi = neg_hi ? (~acc_hi + 32'd1) : acc_hi;
      res_lo = neg_lo ? (~acc_lo + 32'd1) : acc_lo;
    end
  end

  // Control FSM and architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 6'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A pending request outranks MTHI/MTLO; a flush refuses it.
            if (!flush) begin
              count <= 6'd0;
              state <= b_zero ? FIX : CALC;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            count <= count + 6'd1;
            if (count == 6'd31) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            div0  <= zero_div;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers carry no reset; they are always reloaded on
  // accept before being used, so their idle contents never matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div   <= is_div;
      zero_div <= b_zero;
      if (b_zero) begin
        // Divide by zero: HI=a, LO=all ones, passed through FIX unchanged.
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
        opnd   <= b_mag;
        acc_hi <= a;
        acc_lo <= 32'hFFFF_FFFF;
      end else if (is_div) begin
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= a_neg;
        opnd   <= b_mag;
        acc_hi <= 32'd0;
        acc_lo <= a_mag;
      end else begin
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= 1'b0;
        opnd   <= a_mag;
        acc_hi <= 32'd0;
        acc_lo <= b_mag;
      end
    end else if (state == CALC) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed and randomized bench for muldiv_unit. Expected HI/LO come from
// 64-bit integer arithmetic on the operands; stall and done timing come from
// the cycle counts of the operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        done;
  logic        div0;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .stall (stall),
    .done  (done),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference arithmetic: full-width integer multiply and truncating divide.
  task automatic model(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       output logic [31:0] e_hi, output logic [31:0] e_lo,
                       output logic e_d0, output int e_stalls);
    longint      sa;
    longint      sb;
    longint      sp;
    logic [63:0] up;
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    e_d0     = 1'b0;
    e_stalls = 34;
    case (op_i)
      2'b00: begin sp = sa * sb; up = sp; e_hi = up[63:32]; e_lo = up[31:0]; end
      2'b01: begin up = {32'd0, a_i} * {32'd0, b_i}; e_hi = up[63:32]; e_lo = up[31:0]; end
      default: begin
        if (b_i == 32'd0) begin
          e_hi = a_i; e_lo = 32'hFFFF_FFFF; e_d0 = 1'b1; e_stalls = 2;
        end else if (op_i == 2'b10) begin
          sp = sa / sb; up = sp; e_lo = up[31:0];
          sp = sa % sb; up = sp; e_hi = up[31:0];
        end else begin
          e_lo = a_i / b_i;
          e_hi = a_i % b_i;
        end
      end
    endcase
  endtask

  // Issues one request from IDLE (called at posedge+1) and holds start until
  // the cycle after DONE, like an ID/EX register frozen by stall.
  task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input bit we_calc,
                        output logic [31:0] hi_o, output logic [31:0] lo_o, output logic d0_o);
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_d0;
    int          e_stalls;
    int          stalls = 0;
    int          pulses = 0;
    bit          seen   = 0;
    model(op_i, a_i, b_i, e_hi, e_lo, e_d0, e_stalls);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    hi_o = 'x; lo_o = 'x; d0_o = 'x;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      #1;
      if (stall) stalls++;
      @(posedge clk); #1;
      if (we_calc) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (done) begin
        seen = 1; pulses++;
        hi_o = hi; lo_o = lo; d0_o = div0;
      end
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " stall_cycles"}, 64'(stalls), 64'(e_stalls));
    check({tag, " hi"}, 64'(hi_o), 64'(e_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(e_lo));
    check({tag, " div0"}, 64'(d0_o), 64'(e_d0));
    #1;
    check({tag, " stall_in_done"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check({tag, " done_pulses"}, 64'(pulses), 64'd1);
    check({tag, " hi_held"}, 64'(hi), 64'(e_hi));
  endtask

  initial begin
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_d0;
    int          pulses;

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    // Reset state, including reset priority over start and hi_we.
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    reset = 1'b0;
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div0", 64'(div0), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    @(posedge clk); #1;

    // MTHI and MTLO in the same cycle.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt both hi", 64'(hi), 64'h1234_5678);
    check("mt both lo", 64'(lo), 64'h1234_5678);

    // Directed arithmetic cases.
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, r_hi, r_lo, r_d0);
    check("mult_neg hi lit", 64'(r_hi), 64'hFFFF_FFFF);
    check("mult_neg lo lit", 64'(r_lo), 64'hFFFF_FFEB);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r_hi, r_lo, r_d0);
    check("multu_max hi lit", 64'(r_hi), 64'hFFFF_FFFE);
    check("multu_max lo lit", 64'(r_lo), 64'h0000_0001);

    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, r_hi, r_lo, r_d0);
    check("div_neg lo lit", 64'(r_lo), 64'hFFFF_FFFD);
    check("div_neg hi lit", 64'(r_hi), 64'hFFFF_FFFF);

    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 0, r_hi, r_lo, r_d0);
    check("divu_zero hi lit", 64'(r_hi), 64'h0000_0064);
    check("divu_zero div0 lit", 64'(r_d0), 64'd1);

    run_op("div_zero_neg", 2'b10, 32'h8000_0003, 32'd0, 0, r_hi, r_lo, r_d0);

    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, r_hi, r_lo, r_d0);
    check("div_ovf lo lit", 64'(r_lo), 64'h8000_0000);
    check("div_ovf hi lit", 64'(r_hi), 64'd0);
    check("div_ovf div0 lit", 64'(r_d0), 64'd0);

    run_op("div_rem_neg", 2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 0, r_hi, r_lo, r_d0);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0, r_hi, r_lo, r_d0);

    // MTHI/MTLO ignored while busy: hi_we held through CALC, FIX and DONE.
    run_op("mul_we_calc", 2'b01, 32'h0001_0003, 32'h0000_0100, 1, r_hi, r_lo, r_d0);

    // Flush in CALC at count=10.
    hi_we = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    @(posedge clk); #1;
    lo_we = 1'b0;
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    repeat (11) @(posedge clk);
    #1;
    check("flush stall_before", 64'(stall), 64'd1);
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush stall_after", 64'(stall), 64'd0);
    pulses = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("flush done_pulses", 64'(pulses), 64'd0);
    check("flush hi kept", 64'(hi), 64'h1111_1111);
    check("flush lo kept", 64'(lo), 64'h2222_2222);

    // Reset in the middle of a divide at count=20.
    start = 1'b1; op = 2'b10; a = 32'h7654_3210; b = 32'd13;
    repeat (21) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset stall", 64'(stall), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_op("after_reset_mult", 2'b00, 32'hFFFF_8000, 32'h0000_1234, 0, r_hi, r_lo, r_d0);

    // Randomized operations.
    for (int i = 0; i < 14; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if (i % 3 == 0) r_b = $urandom_range(1, 15);
      if (i % 5 == 4) r_b = 32'd0;
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, 0, r_hi, r_lo, r_d0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: ID/EX-registered request for a multiply or divide instruction.
REQ-004 SHALL have port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports a and b, input, 32 bits each: A and B operands from the ID/EX register.
REQ-006 SHALL have port flush, input, 1 bit: exception flush; abort or refuse the operation.
REQ-007 SHALL have ports hi_we and lo_we, input, 1 bit each: MTHI and MTLO write enables.
REQ-008 SHALL have port wdata, input, 32 bits: MTHI/MTLO write data.
REQ-009 SHALL have ports hi and lo, output, 32 bits each: HI and LO architectural registers.
REQ-010 SHALL have port stall, output, 1 bit, combinational: freeze PC, IF/ID and ID/EX.
REQ-011 SHALL have port done, output, 1 bit, registered: one-cycle pulse when HI and LO are updated.
REQ-012 SHALL have port div0, output, 1 bit, registered: divide-by-zero flag, valid while done=1.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL transition IDLE->CALC on the clock edge where start=1, flush=0 and reset=0; at that edge it latches op, operand magnitudes (signed ops), result-sign bits, and clears the 6-bit count.
REQ-015 SHALL run exactly 32 CALC cycles, one bit per cycle, incrementing count each cycle, and go to FIX when count=31.
- Multiply: shift-add on the 64-bit {hi_acc, lo_acc}.
- Divide: restoring division.
REQ-016 SHALL, in FIX (1 cycle), negate the results where the sign bits require and write HI and LO, then go to DONE.
- Signed multiply: negate the 64-bit product if a[31]^b[31].
- Signed divide: negate the quotient if a[31]^b[31]; negate the remainder if a[31].
REQ-017 SHALL hold done=1 in DONE for one cycle, ignore start, and return to IDLE on the next cycle.
REQ-018 SHALL drive stall = (state==CALC) | (state==FIX) | (state==IDLE & start & ~flush).
- This gives 34 stall cycles per operation.
- stall=0 in DONE, so the requesting instruction leaves ID/EX and cannot re-trigger.
REQ-019 SHALL place results for a multiply as HI = product[63:32] and LO = product[31:0].
REQ-020 SHALL place results for a divide as LO = quotient and HI = remainder.
REQ-021 SHALL, on divide with b=0, skip CALC (IDLE->FIX->DONE) and set HI=a, LO=32'hFFFFFFFF, div0=1.
REQ-022 SHALL give signed overflow 0x80000000 / 0xFFFFFFFF the result LO=0x80000000, HI=0, div0=0.
REQ-023 SHALL, on flush=1 in CALC or FIX, go to IDLE on the next edge with HI/LO unchanged, done=0 and stall deasserted from that cycle.
REQ-024 SHALL, in IDLE with start=0, write HI<=wdata on hi_we=1 and LO<=wdata on lo_we=1 at the next edge; both may be written in the same cycle.
REQ-025 SHALL ignore hi_we and lo_we in CALC, FIX and DONE, and when start=1 in IDLE (start has priority).
REQ-026 SHALL hold hi and lo constant except as updated by REQ-016, REQ-021 and REQ-024.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set state=IDLE, count=0, hi=0, lo=0, done=0 and div0=0.
REQ-028 SHALL give reset priority over start, flush, hi_we and lo_we.
- stall=0 in the cycle after reset.
- An operation in progress is discarded.
REQ-029 SHALL keep internal accumulator and operand registers free of any reset-value dependency; they are don't-care in IDLE.

Verification
REQ-030 SHALL be covered by a test where MULT a=0xFFFFFFFD, b=0x00000007 -> after 34 stall cycles, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 SHALL be covered by a test where MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL be covered by a test where DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div0=1, stall high for 2 cycles.
REQ-033 SHALL be covered by a test where MULTU 5*6 is started, then flush=1 at CALC count=10 -> stall=0 on the following cycle, done never asserts, hi/lo keep the prior MTHI/MTLO values 0x11111111/0x22222222.
REQ-034 SHALL be covered by a test where reset=1 mid-DIV at count=20 -> next cycle hi=lo=0, stall=0, done=0; a subsequent MULT completes correctly.
REQ-035 SHALL be covered by a test where start is held high through DONE -> exactly one done pulse and no second operation; hi_we asserted during CALC -> HI takes the arithmetic result, not wdata.
